// File: rtl/ahb_seg_key_regs.sv
// ---------------------------------------------------------------------------
// ahb_seg_key_regs
// AHB-Lite slave with four word registers, driving a 4-digit 7-segment
// display word and debouncing four active-low push-buttons.
//
// Register map (HADDR[3:2]):
//   0x0 SEG_DATA RW [19:0]  digit k hex code at [5k+3:5k], dp at [5k+4]
//   0x4 KEY_LVL  RO [3:0]   debounced key levels (pressed = 1)
//   0x8 KEY_EVT  W1C[3:0]   sticky press events
//   0xC CTRL     RW [0]     IRQ_EN
//
// Ports:
//   HCLK, HRESETn                clock, async active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/    AHB-Lite address phase inputs
//   HSIZE/HREADY                 (HSIZE ignored, every access is a word)
//   HWDATA                       write data (data phase)
//   HRDATA/HREADYOUT/HRESP       read data, always ready, always OKAY
//   KEY_N                        raw asynchronous buttons, active-low
//   DATA                         {12'b0, SEG_DATA}
//   IRQ                          registered IRQ_EN & |KEY_EVT
// ---------------------------------------------------------------------------
module ahb_seg_key_regs #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic [3:0]  KEY_N,
    output logic [31:0] DATA,
    output logic        IRQ
);

    localparam logic [1:0] A_SEG  = 2'd0;
    localparam logic [1:0] A_LVL  = 2'd1;
    localparam logic [1:0] A_EVT  = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    localparam logic [15:0] DB_LAST = DB_CYCLES - 16'd1;

    // Address-phase capture and data-phase state
    logic        dvalid_q;
    logic [1:0]  daddr_q;
    logic        dwrite_q;
    logic        addr_sel_s;
    logic        wr_en_s;
    logic        rd_en_s;

    // Register file
    logic [19:0] seg_q;
    logic        ctrl_q;
    logic [3:0]  key_lvl_q;
    logic [3:0]  key_lvl_d;
    logic [3:0]  key_evt_q;
    logic [3:0]  key_evt_d;
    logic        irq_q;

    // Key synchronisers (stored already inverted: 1 = pressed) and debounce
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic [3:0][15:0]  cnt_q;
    logic [3:0][15:0]  cnt_d;
    logic [3:0]        rise_s;
    logic [3:0]        clr_s;

    logic unused_s;
    assign unused_s = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:20]};

    assign addr_sel_s = HSEL & HREADY & HTRANS[1];
    assign wr_en_s    = dvalid_q & dwrite_q;
    assign rd_en_s    = dvalid_q & ~dwrite_q;

    // Capture the address phase; the valid flag drops on any non-transfer cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dvalid_q <= 1'b0;
            daddr_q  <= 2'd0;
            dwrite_q <= 1'b0;
        end else begin
            dvalid_q <= addr_sel_s;
            if (addr_sel_s) begin
                daddr_q  <= HADDR[3:2];
                dwrite_q <= HWRITE;
            end
        end
    end

    // Data-phase writes to the plain RW registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            seg_q  <= 20'd0;
            ctrl_q <= 1'b0;
        end else begin
            if (wr_en_s && (daddr_q == A_SEG)) begin
                seg_q <= HWDATA[19:0];
            end
            if (wr_en_s && (daddr_q == A_CTRL)) begin
                ctrl_q <= HWDATA[0];
            end
        end
    end

    // Two-flop synchroniser; inversion happens at the first stage
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= ~KEY_N;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a key level flips only after DB_CYCLES consecutive mismatches
    always_comb begin
        cnt_d     = cnt_q;
        key_lvl_d = key_lvl_q;
        rise_s    = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] == key_lvl_q[k]) begin
                cnt_d[k] = 16'd0;
            end else if (cnt_q[k] == DB_LAST) begin
                cnt_d[k]     = 16'd0;
                key_lvl_d[k] = ~key_lvl_q[k];
                rise_s[k]    = ~key_lvl_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // W1C clear mask; a coincident set overrides the clear below
    always_comb begin
        if (wr_en_s && (daddr_q == A_EVT)) begin
            clr_s = HWDATA[3:0];
        end else begin
            clr_s = 4'd0;
        end
        key_evt_d = (key_evt_q & ~clr_s) | rise_s;
    end

    // Key level, event and counter state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q     <= {4{16'd0}};
            key_lvl_q <= 4'd0;
            key_evt_q <= 4'd0;
        end else begin
            cnt_q     <= cnt_d;
            key_lvl_q <= key_lvl_d;
            key_evt_q <= key_evt_d;
        end
    end

    // Interrupt follows the registers with one cycle of latency
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_q & (|key_evt_q);
        end
    end

    // Read mux, active only in a valid read data phase
    always_comb begin
        HRDATA = 32'd0;
        if (rd_en_s) begin
            case (daddr_q)
                A_SEG:   HRDATA = {12'd0, seg_q};
                A_LVL:   HRDATA = {28'd0, key_lvl_q};
                A_EVT:   HRDATA = {28'd0, key_evt_q};
                A_CTRL:  HRDATA = {31'd0, ctrl_q};
                default: HRDATA = 32'd0;
            endcase
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign DATA      = {12'd0, seg_q};
    assign IRQ       = irq_q;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule

// File: doc/ahb_seg_key_regs.md
AHB_SEG_KEY_REGS -- requirements
Module: ahb_seg_key_regs

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16'd50000, consecutive stable cycles required to accept a key level change (range 2..65535).
REQ-002 SHALL have port HCLK  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port HSEL  input  1  AHB-Lite slave select.
REQ-005 SHALL have port HADDR  input  32  AHB address; only HADDR[3:2] decoded.
REQ-006 SHALL have port HTRANS  input  2  transfer type; HTRANS[1]=1 marks NONSEQ/SEQ.
REQ-007 SHALL have port HWRITE  input  1  1 = write.
REQ-008 SHALL have port HSIZE  input  3  ignored; every access is treated as a word.
REQ-009 SHALL have port HREADY  input  1  bus ready from the interconnect.
REQ-010 SHALL have port HWDATA  input  32  write data, valid in the data phase.
REQ-011 SHALL have port HRDATA  output  32  read data, valid in the data phase.
REQ-012 SHALL have port HREADYOUT  output  1  tied 1 (zero wait states).
REQ-013 SHALL have port HRESP  output  1  tied 0 (OKAY).
REQ-014 SHALL have port KEY_N  input  4  raw asynchronous push-buttons, active-low.
REQ-015 SHALL have port DATA  output  32  display word to the 4-digit driver: digit k hex code at [5k+3:5k], dp at [5k+4], k=0..3; [31:20]=0.
REQ-016 SHALL have port IRQ  output  1  key-event interrupt, active-high, registered.

Function
REQ-017 SHALL capture the address phase (HADDR[3:2], HWRITE) into registers only when HSEL & HREADY & HTRANS[1]; otherwise the data-phase valid flag clears.
REQ-018 SHALL perform the write in the data phase (cycle after capture) using HWDATA; the register updates on the following HCLK edge.
REQ-019 SHALL drive HRDATA combinationally from the captured address during a valid read data phase; 0 otherwise.
REQ-020 SHALL implement the register map: 0x0 SEG_DATA RW [19:0]; 0x4 KEY_LVL RO [3:0]; 0x8 KEY_EVT W1C [3:0]; 0xC CTRL RW [0]=IRQ_EN; unused bits read 0, writes to RO bits ignored.
REQ-021 SHALL drive DATA = {12'b0, SEG_DATA[19:0]} directly from the register (new value visible one cycle after the write data phase).
REQ-022 SHALL synchronise each KEY_N bit through two flip-flops and invert it (pressed = 1).
REQ-023 SHALL, per key, run a 16-bit counter: reset to 0 whenever the synchronised level equals KEY_LVL; otherwise increment; when it reaches DB_CYCLES-1, KEY_LVL bit toggles and counter returns to 0.
REQ-024 SHALL set KEY_EVT[k] in the same cycle KEY_LVL[k] transitions 0->1; release (1->0) sets nothing.
REQ-025 SHALL clear KEY_EVT[k] on a write to 0x8 with HWDATA[k]=1; if set and clear coincide, set wins.
REQ-026 SHALL register IRQ = IRQ_EN & |KEY_EVT (one cycle after the contributing register changes).
REQ-027 SHALL, for a glitch shorter than DB_CYCLES cycles, leave KEY_LVL, KEY_EVT and IRQ unchanged.
REQ-028 SHALL accept back-to-back transfers (pipelined address/data phases) with no stall; a read immediately after a write to the same address returns the new value.

Reset
REQ-029 SHALL, on HRESETn low, asynchronously clear SEG_DATA, KEY_LVL, KEY_EVT, CTRL, debounce counters, synchronisers, address-phase registers and IRQ; DATA=0, HRDATA=0, HREADYOUT=1, HRESP=0.
REQ-030 SHALL, on reset assertion mid-debounce or mid-transfer, abandon the operation; no event or write completes after release.

Verification
REQ-031 Write 0x000A_5F21 to 0x0 -> DATA=0x000A_5F21 one cycle after data phase; read 0x0 returns 0x000A_5F21, read 0x4 returns 0 with keys idle.
REQ-032 DB_CYCLES=8, KEY_N[2] low for 20 cycles -> KEY_LVL=0x4 after 2 sync + 8 cycles; KEY_EVT=0x4; IRQ=1 only if CTRL[0]=1.
REQ-033 DB_CYCLES=8, KEY_N[0] low 5 cycles then high -> KEY_LVL, KEY_EVT remain 0.
REQ-034 KEY_EVT=0x5, write 0x1 to 0x8 -> KEY_EVT=0x4, IRQ stays 1; write 0x4 -> KEY_EVT=0, IRQ=0 next cycle; coincident new press on bit 2 during clear -> bit 2 remains 1.
REQ-035 Back-to-back write 0x1 to 0xC then read 0xC -> HRDATA=0x1, HREADYOUT=1 throughout; HTRANS=IDLE or HSEL=0 transfers leave all registers unchanged.
REQ-036 Assert HRESETn low during debounce and after SEG_DATA write -> all outputs at reset values immediately, no event after release.
